// File: rtl/rv_fetch_aligner.sv
// rtl/rv_fetch_aligner.sv - fetch PC owner and halfword re-aligner feeding whole instructions to the decoder
module rv_fetch_aligner #(
  parameter bit          rv64     = 1'b1,
  parameter logic [63:0] reset_pc = 64'h0,
  localparam int         XLEN     = rv64 ? 64 : 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [31:0]     mem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DROP} state_t;

  localparam logic [XLEN-1:0] RST_PC = reset_pc[XLEN-1:0];

  state_t          state;
  logic [15:0]     hb [3];
  logic [1:0]      count;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] fetch_addr;
  logic            skip_low;

  logic            cmp;
  logic            pop;
  logic            keep;
  logic [1:0]      pop_n;
  logic [1:0]      app_n;
  logic [1:0]      count_popped;
  logic [1:0]      count_next;
  logic [15:0]     app0;
  logic [15:0]     app1;
  logic [15:0]     hb_popped [3];
  logic [15:0]     hb_next [3];

  assign cmp           = hb[0][1:0] != 2'b11;
  assign inst_valid    = !redirect && (cmp ? count >= 2'd1 : count >= 2'd2);
  assign inst          = cmp ? {16'b0, hb[0]} : {hb[1], hb[0]};
  assign inst_pc       = pc;
  assign mem_req_valid = (state == FETCH) && !redirect && count <= 2'd1;
  assign mem_req_addr  = fetch_addr;
  assign pop           = inst_valid && inst_ready;
  assign keep          = (state == WAIT) && mem_resp_valid && !redirect;

  // Pop happens first, then the kept response lands right after the survivors.
  always_comb begin
    pop_n = 2'd0;
    if (pop) pop_n = cmp ? 2'd1 : 2'd2;
    count_popped = count - pop_n;
    for (int i = 0; i < 3; i++) hb_popped[i] = hb[i];
    if (pop_n == 2'd1) begin
      hb_popped[0] = hb[1];
      hb_popped[1] = hb[2];
    end else if (pop_n == 2'd2) begin
      hb_popped[0] = hb[2];
    end
    app0  = skip_low ? mem_resp_data[31:16] : mem_resp_data[15:0];
    app1  = mem_resp_data[31:16];
    app_n = !keep ? 2'd0 : (skip_low ? 2'd1 : 2'd2);
    count_next = count_popped + app_n;
    for (int i = 0; i < 3; i++) begin
      hb_next[i] = hb_popped[i];
      if (2'(i) == count_popped && app_n != 2'd0) hb_next[i] = app0;
      else if (2'(i) == count_popped + 2'd1 && app_n == 2'd2) hb_next[i] = app1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      count      <= 2'd0;
      pc         <= RST_PC;
      fetch_addr <= {RST_PC[XLEN-1:2], 2'b00};
      skip_low   <= RST_PC[1];
      for (int i = 0; i < 3; i++) hb[i] <= 16'h0;
    end else if (redirect) begin
      count      <= 2'd0;
      pc         <= redirect_pc & ~{{(XLEN-1){1'b0}}, 1'b1};
      fetch_addr <= {redirect_pc[XLEN-1:2], 2'b00};
      skip_low   <= redirect_pc[1];
      // A request still in flight must be swallowed before fetching again.
      case (state)
        WAIT, DROP: state <= mem_resp_valid ? FETCH : DROP;
        default:    state <= FETCH;
      endcase
    end else begin
      for (int i = 0; i < 3; i++) hb[i] <= hb_next[i];
      count <= count_next;
      if (pop) pc <= pc + {{(XLEN-3){1'b0}}, pop_n, 1'b0};
      if (keep) skip_low <= 1'b0;
      case (state)
        IDLE:  state <= FETCH;
        FETCH: begin
          if (mem_req_valid && mem_req_ready) begin
            fetch_addr <= fetch_addr + {{(XLEN-3){1'b0}}, 3'd4};
            state      <= WAIT;
          end
        end
        WAIT:    if (mem_resp_valid) state <= FETCH;
        DROP:    if (mem_resp_valid) state <= FETCH;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_fetch_aligner.sv
// tb/tb_rv_fetch_aligner.sv - randomized bench for rv_fetch_aligner against an instruction-stream model
module tb_rv_fetch_aligner;
  localparam int XLEN = 64;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            redirect = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            mem_req_valid;
  logic            mem_req_ready = 1'b0;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_resp_valid = 1'b0;
  logic [31:0]     mem_resp_data = '0;
  logic            inst_valid;
  logic            inst_ready = 1'b0;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;

  always #5 clock = ~clock;

  rv_fetch_aligner #(.rv64(1'b1), .reset_pc(64'h0)) dut (
    .clock(clock), .reset_n(reset_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] mem [256];

  function automatic logic [15:0] rand_hw();
    logic [15:0] h;
    h = 16'($urandom);
    if ($urandom_range(1, 0) == 1) h[1:0] = 2'b11;
    else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
    return h;
  endfunction

  function automatic logic [15:0] hw_at(input logic [63:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [31:0] exp_inst(input logic [63:0] p);
    logic [15:0] h0;
    h0 = hw_at(p);
    if (h0[1:0] != 2'b11) return {16'h0, h0};
    return {hw_at(p + 64'd2), h0};
  endfunction

  initial begin
    logic [63:0] model_pc, exp_faddr, pend_addr, prev_req_addr, prev_inst_pc, prev_rpc;
    logic [31:0] prev_inst;
    logic        pend_valid, prev_req_valid, prev_req_ready, prev_inst_valid, prev_inst_ready;
    logic        prev_redirect, dir_done, dir_wait_addr, dir_wait_inst, acc;
    int          pend_delay, consumed, quiet;

    for (int i = 0; i < 256; i++) mem[i] = {rand_hw(), rand_hw()};
    mem[0]    = 32'h00134081;
    mem[1]    = 32'h40810000;
    mem[8'h40] = 32'h00014081;

    repeat (2) @(negedge clock);
    #1;
    check_eq("rst_req_valid", mem_req_valid, 0);
    check_eq("rst_inst_valid", inst_valid, 0);
    check_eq("rst_req_addr", mem_req_addr, 0);
    check_eq("rst_inst_pc", inst_pc, 0);
    @(negedge clock);
    reset_n = 1'b1;

    model_pc = 0; exp_faddr = 0; pend_valid = 0; pend_addr = 0; pend_delay = 0;
    prev_req_valid = 0; prev_req_ready = 0; prev_req_addr = 0;
    prev_inst_valid = 0; prev_inst_ready = 0; prev_inst = 0; prev_inst_pc = 0;
    prev_redirect = 0; prev_rpc = 0; dir_done = 0; dir_wait_addr = 0; dir_wait_inst = 0;
    consumed = 0; quiet = 0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      redirect = 1'b0;
      if (cyc >= 40 && !dir_done && pend_valid) begin
        redirect = 1'b1; redirect_pc = 64'h102;
        dir_done = 1; dir_wait_addr = 1; dir_wait_inst = 1; quiet = 80;
      end else if (dir_done && quiet == 0 && !dir_wait_inst && !dir_wait_addr &&
                   $urandom_range(19, 0) == 0) begin
        redirect = 1'b1; redirect_pc = {54'b0, 10'($urandom)};
      end
      if (quiet > 0) quiet--;
      mem_req_ready  = $urandom_range(3, 0) != 0;
      inst_ready     = (cyc < 40) ? 1'b1 : ($urandom_range(3, 0) != 0);
      mem_resp_valid = pend_valid && pend_delay == 0;
      mem_resp_data  = mem_resp_valid ? mem[pend_addr[9:2]] : $urandom;
      #1;

      if (cyc == 0) check_eq("first_req_idle", mem_req_valid, 0);
      if (cyc == 1) check_eq("first_req_rise", mem_req_valid, 1);
      if (redirect) begin
        check_eq("redir_no_inst", inst_valid, 0);
        check_eq("redir_no_req", mem_req_valid, 0);
      end
      if (prev_redirect && !redirect) check_eq("redir_pc", inst_pc, prev_rpc & ~64'h1);
      if (mem_req_valid) check_eq("one_outstanding", pend_valid, 0);
      if (prev_req_valid && !prev_req_ready && !redirect) begin
        check_eq("req_hold_valid", mem_req_valid, 1);
        check_eq("req_hold_addr", mem_req_addr, prev_req_addr);
      end
      if (prev_inst_valid && !prev_inst_ready && !redirect) begin
        check_eq("inst_hold_valid", inst_valid, 1);
        check_eq("inst_hold", inst, prev_inst);
        check_eq("inst_hold_pc", inst_pc, prev_inst_pc);
      end

      acc = mem_req_valid && mem_req_ready;
      if (acc) begin
        check_eq("req_addr", mem_req_addr, exp_faddr);
        if (dir_wait_addr) begin
          check_eq("redir_req_addr", mem_req_addr, 64'h100);
          dir_wait_addr = 0;
        end
        exp_faddr = exp_faddr + 64'd4;
      end
      if (mem_resp_valid) pend_valid = 0;
      else if (pend_valid && pend_delay > 0) pend_delay--;
      if (acc) begin
        pend_valid = 1; pend_addr = mem_req_addr; pend_delay = $urandom_range(3, 0);
      end

      if (inst_valid && inst_ready) begin
        check_eq("inst", inst, exp_inst(model_pc));
        check_eq("inst_pc", inst_pc, model_pc);
        if (consumed == 0) begin check_eq("basic_inst0", inst, 32'h4081); check_eq("basic_pc0", inst_pc, 0); end
        if (consumed == 1) begin check_eq("straddle_inst", inst, 32'h13); check_eq("straddle_pc", inst_pc, 2); end
        if (consumed == 2) begin check_eq("after_inst", inst, 32'h4081); check_eq("after_pc", inst_pc, 6); end
        if (dir_wait_inst) begin
          check_eq("redir_inst", inst, 32'h1);
          check_eq("redir_inst_pc", inst_pc, 64'h102);
          dir_wait_inst = 0;
        end
        model_pc = model_pc + ((exp_inst(model_pc) >> 16) == 0 && hw_at(model_pc)[1:0] != 2'b11 ? 64'd2 : 64'd4);
        consumed++;
      end
      if (redirect) begin
        model_pc  = redirect_pc & ~64'h1;
        exp_faddr = redirect_pc & ~64'h3;
      end

      prev_req_valid = mem_req_valid; prev_req_ready = mem_req_ready; prev_req_addr = mem_req_addr;
      prev_inst_valid = inst_valid; prev_inst_ready = inst_ready;
      prev_inst = inst; prev_inst_pc = inst_pc;
      prev_redirect = redirect; prev_rpc = redirect_pc;
      @(negedge clock);
    end

    check_eq("redir_seen", {62'b0, dir_wait_addr, dir_wait_inst}, 0);
    check_eq("consumed_enough", consumed >= 300, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
